// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and widths for the uart_tx arbiter.
package uart_pkg;
  localparam int BYTE_W      = 8;
  localparam int DEF_NUM_REQ = 4;
  typedef enum logic [2:0] {IDLE, OWN, START, WAIT_HI, WAIT_LO} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request above ptr with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    // Walk from the farthest candidate down so the nearest one above ptr wins.
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BUSY_WAIT = 15
) (
  input  logic                      clk_25mhz,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_WAIT + 1);
  state_t               state;
  logic [IW-1:0]        ptr, own, pick_idx;
  logic [NUM_REQ-1:0]   pick;
  logic                 last_r, done;
  logic [CW-1:0]        cnt;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx)
  );
  assign req_ready = {NUM_REQ{state == OWN}} & grant;
  // A busy timeout finishes the byte exactly like a normal busy fall.
  assign done = !tx_busy && (state == WAIT_LO || (state == WAIT_HI && cnt == CW'(BUSY_WAIT - 1)));
  always_ff @(posedge clk_25mhz) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      ptr         <= IW'(NUM_REQ - 1);
      own         <= '0;
      last_r      <= 1'b0;
      cnt         <= '0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant <= pick;
          own   <= pick_idx;
          state <= OWN;
        end
        OWN: if (req_valid[own]) begin
          tx_data <= req_data[BYTE_W*own +: BYTE_W];
          last_r  <= req_last[own];
          state   <= START;
        end
        START: begin
          tx_start <= 1'b1;
          cnt      <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: if (tx_busy) state <= WAIT_LO; else cnt <= cnt + 1'b1;
        default: state <= state;
      endcase
      if (done) begin
        err_timeout <= state == WAIT_HI;
        state       <= last_r ? IDLE : OWN;
        if (last_r) begin
          ptr   <= own;
          grant <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int BUSY_CYC = 6;
  logic             clk_25mhz = 1'b0;
  logic             resetn = 1'b0;
  logic [N-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*N-1:0]   req_data;
  logic [7:0]       tx_data;
  logic             tx_start, tx_busy, err_timeout;
  logic [8:0]       q[N][$];
  logic [11:0]      exp_q[$];
  logic [N-1:0]     pause = '0, hs;
  logic             mute = 1'b0, st;
  int               bcnt = 0, cyc = 0, n_cmp = 0, n_bad = 0, to_cnt = 0, last_start = 0, err_cyc = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT(15)) dut (
    .clk_25mhz(clk_25mhz), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  initial begin
    logic [8:0] h;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    forever begin
      @(negedge clk_25mhz);
      hs = req_valid & req_ready;
      st = tx_start;
      @(posedge clk_25mhz);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
        h = q[i].size() > 0 ? q[i][0] : 9'h0;
        req_valid[i] = q[i].size() > 0 && !pause[i];
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end
      if (!resetn) bcnt = 0;
      else if (st && !mute) bcnt = BUSY_CYC;
      else if (bcnt > 0) bcnt--;
      tx_busy = bcnt > 0;
    end
  end

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk_25mhz);
      if (resetn && err_timeout) begin
        to_cnt++;
        err_cyc = cyc;
      end
      if (resetn && tx_start) begin
        last_start = cyc;
        if (exp_q.size() == 0) chk("unexpected_tx_start", {grant, tx_data}, 12'h0);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", {20'h0, grant, tx_data}, {20'h0, e});
        end
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q[r].push_back({l, d});
    exp_q.push_back({4'(1 << r), d});
  endtask

  task automatic do_reset();
    @(negedge clk_25mhz);
    resetn = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    pause = '0;
    repeat (2) @(negedge clk_25mhz);
    resetn = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (k < 400 && !(exp_q.size() == 0 && grant == '0 && !tx_busy)) begin
      @(negedge clk_25mhz);
      k++;
    end
    chk(nm, {31'h0, k < 400}, 32'h1);
  endtask

  initial begin
    int t0, k;
    repeat (2) @(negedge clk_25mhz);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_err", err_timeout, 0);
    resetn = 1'b1;
    @(negedge clk_25mhz);
    push(0, 8'h55, 1'b1);
    k = 0;
    while (!req_valid[0] && k < 10) begin @(negedge clk_25mhz); k++; end
    t0 = cyc;
    k = 0;
    while (!tx_start && k < 20) begin @(negedge clk_25mhz); k++; end
    chk("start_latency", cyc - t0, 3);
    chk("grant_held_in_tx", grant, 4'b0001);
    wait_done("single_release");
    chk("single_ready_idle", req_ready, 0);

    do_reset();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    push(1, 8'h43, 1'b1);
    wait_done("two_req_packets");

    do_reset();
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    push(0, 8'h14, 1'b1);
    wait_done("rr_wrap");

    push(2, 8'hA0, 1'b0);
    q[2].push_back({1'b1, 8'hA1});
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk_25mhz); k++; end
    @(negedge clk_25mhz);
    resetn = 1'b0;
    q[2].delete();
    @(negedge clk_25mhz);
    chk("midrst_grant", grant, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_tx_data", tx_data, 0);
    resetn = 1'b1;
    push(0, 8'h60, 1'b1);
    push(1, 8'h61, 1'b1);
    wait_done("post_reset_priority");

    push(0, 8'h80, 1'b0);
    push(0, 8'h81, 1'b0);
    push(0, 8'h82, 1'b1);
    k = 0;
    while (grant != 4'b0001 && k < 20) begin @(negedge clk_25mhz); k++; end
    push(2, 8'h90, 1'b1);
    k = 0;
    while (q[0].size() != 2 && k < 20) begin @(negedge clk_25mhz); k++; end
    pause[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_25mhz);
      chk("pause_grant", grant, 4'b0001);
      chk("pause_ready2", {31'h0, req_ready[2]}, 0);
    end
    pause[0] = 1'b0;
    wait_done("pause_resume");

    mute = 1'b1;
    push(3, 8'h70, 1'b0);
    push(3, 8'h71, 1'b1);
    k = 0;
    while (to_cnt == 0 && k < 100) begin @(negedge clk_25mhz); k++; end
    mute = 1'b0;
    chk("timeout_delay", err_cyc - last_start, 15);
    wait_done("timeout_continue");
    chk("timeout_count", to_cnt, 1);
    chk("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
